// File: rtl/mask_wr_packer.sv
// Packs per-element ALU compare/mask bits into mask-file words and drives the
// mask register file write port (byte enables, register, packet offset, data).
module mask_wr_packer #(
    parameter int DATA_WIDTH   = 64,
    parameter int DW_B         = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int OFF_BITS     = 8,
    parameter int PACK_PER_REG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_vd,
    input  logic [1:0]            start_sew,
    input  logic                  in_valid,
    input  logic [7:0]            in_bits,
    input  logic                  in_last,
    output logic [DW_B-1:0]       wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [OFF_BITS-1:0]   wr_off,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int FILL_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   vd_q, vd_d;
    logic [1:0]              sew_q, sew_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [OFF_BITS-1:0]     off_q, off_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic                    err_q, err_d;
    logic [DW_B-1:0]         wr_en_q, wr_en_d;
    logic [OFF_BITS-1:0]     wr_off_q, wr_off_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    done_q, done_d;

    // Beat decode: bits per beat and the masked payload for the latched element width.
    logic [FILL_W-1:0]       beat_n;
    logic [7:0]              beat_bits;
    logic [DATA_WIDTH-1:0]   appended;
    logic [FILL_W-1:0]       fill_sum;
    logic [FILL_W-1:0]       byte_cnt;
    logic [DW_B-1:0]         byte_mask;
    logic                    word_full;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        beat_n    = FILL_W'(8);
        beat_bits = in_bits;
        unique case (sew_q)
            2'd0: begin beat_n = FILL_W'(8); beat_bits = in_bits;               end
            2'd1: begin beat_n = FILL_W'(4); beat_bits = {4'b0, in_bits[3:0]};  end
            2'd2: begin beat_n = FILL_W'(2); beat_bits = {6'b0, in_bits[1:0]};  end
            2'd3: begin beat_n = FILL_W'(1); beat_bits = {7'b0, in_bits[0]};    end
            default: ;
        endcase

        appended  = acc_q | (DATA_WIDTH'(beat_bits) << fill_q);
        fill_sum  = fill_q + beat_n;
        word_full = (fill_sum == FILL_W'(DATA_WIDTH));
        byte_cnt  = (fill_sum + FILL_W'(7)) >> 3;
        for (int j = 0; j < DW_B; j++) begin
            byte_mask[j] = (j < int'(byte_cnt));
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        vd_d      = vd_q;
        sew_d     = sew_q;
        fill_d    = fill_q;
        off_d     = off_q;
        acc_d     = acc_q;
        err_d     = err_q;
        wr_en_d   = '0;
        wr_off_d  = wr_off_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PACK;
                    vd_d    = start_vd;
                    sew_d   = start_sew;
                    fill_d  = '0;
                    off_d   = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                end
            end
            PACK: begin
                if (in_valid) begin
                    acc_d  = appended;
                    fill_d = fill_sum;
                    if (word_full || in_last) begin
                        wr_off_d  = off_q;
                        wr_data_d = appended;
                        if (int'(off_q) < PACK_PER_REG) begin
                            wr_en_d = byte_mask;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (word_full) begin
                        // Saturate so a very long operation can never wrap back into range.
                        off_d  = (off_q != '1) ? off_q + OFF_BITS'(1) : off_q;
                        acc_d  = '0;
                        fill_d = '0;
                    end
                    if (in_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            vd_q      <= '0;
            sew_q     <= '0;
            fill_q    <= '0;
            off_q     <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_off_q  <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vd_q      <= vd_d;
            sew_q     <= sew_d;
            fill_q    <= fill_d;
            off_q     <= off_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_off_q  <= wr_off_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = vd_q;
    assign wr_off  = wr_off_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == PACK);
    assign done    = done_q;
    assign err     = err_q;

endmodule
